// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared memory command codes and arbiter FSM encodings
package mem_arbiter_pkg;

    localparam logic [1:0] MREAD  = 2'b00;
    localparam logic [1:0] MWRITE = 2'b01;
    localparam logic [1:0] MNONE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDCAP = 2'd2
    } arb_state_t;

    // Both 2'b10 and 2'b11 are no-ops; only the MSB matters.
    function automatic logic is_noop(input logic [1:0] cmd);
        return cmd[1];
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] win
);

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        win    = 2'b00;
        win[0] = req0 & (~req1 | last);
        win[1] = req1 & (~req0 | ~last);
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and sequencer for the shared RAM
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [1:0]    cmd0,
    input  logic [1:0]    cmd1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] data_out
);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          last;
    logic          owner;
    logic [1:0]    cmd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    win;

    rr_arb2 u_rr_arb2 (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .win  (win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|win) state_nxt = ISSUE;
            ISSUE:   state_nxt = (cmd_q == MREAD) ? RDCAP : IDLE;
            RDCAP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last    <= 1'b1;
            owner   <= 1'b0;
            cmd_q   <= MNONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= (state == RDCAP) && !owner;
            rvalid1 <= (state == RDCAP) && owner;
            if (state == IDLE && |win) begin
                owner   <= win[1];
                last    <= win[1];
                cmd_q   <= win[1] ? cmd1   : cmd0;
                addr_q  <= win[1] ? addr1  : addr0;
                wdata_q <= win[1] ? wdata1 : wdata0;
            end
            // The select bit routes reads away from the RAM: return zero, never sampled data.
            if (state == RDCAP) begin
                if (owner) begin
                    rdata1 <= addr_q[AW-1] ? '0 : data_out;
                end else begin
                    rdata0 <= addr_q[AW-1] ? '0 : data_out;
                end
            end
        end
    end

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        mem_cmd    = MNONE;
        mem_addr   = '0;
        write_data = '0;
        if (state == ISSUE) begin
            gnt0       = !owner;
            gnt1       = owner;
            mem_cmd    = is_noop(cmd_q) ? MNONE : cmd_q;
            mem_addr   = addr_q;
            write_data = wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        logic [15:0] data;
        int          gcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  cmd0 = MNONE, cmd1 = MNONE;
    logic [8:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] data_out;

    logic [15:0] ram [256];
    logic [15:0] shadow [256];

    req_t  pend0[$], pend1[$];
    exp_t  exp0[$], exp1[$];
    int    glog[$];
    int    total = 0, bad = 0, cyc = 0;
    logic  got0 = 1'b0, got1 = 1'b0;
    int    gcount[2] = '{0, 0};
    int    raise_cyc[2] = '{0, 0};
    int    lat[2] = '{0, 0};

    mem_arbiter #(.AW(9), .DW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .cmd0       (cmd0),
        .cmd1       (cmd1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // MEM: synchronous-read RAM, writes with the select bit set are dropped.
    always @(posedge clk) begin
        if (mem_cmd == MWRITE && !mem_addr[8]) ram[mem_addr[7:0]] <= write_data;
        data_out <= ram[mem_addr[7:0]];
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic on_gnt(input int p);
        logic [1:0]  c;
        logic [8:0]  a;
        logic [15:0] w;
        exp_t        e;
        c = (p == 1) ? cmd1 : cmd0;
        a = (p == 1) ? addr1 : addr0;
        w = (p == 1) ? wdata1 : wdata0;
        expect_eq("gnt_onehot", {31'd0, gnt0 & gnt1}, 0);
        expect_eq("gnt_with_req", {31'd0, (p == 1) ? req1 : req0}, 1);
        expect_eq("gnt_mem_cmd", {30'd0, mem_cmd}, {30'd0, c[1] ? MNONE : c});
        expect_eq("gnt_mem_addr", {23'd0, mem_addr}, {23'd0, a});
        if (c == MWRITE) begin
            expect_eq("gnt_write_data", {16'd0, write_data}, {16'd0, w});
            if (!a[8]) shadow[a[7:0]] = w;
        end
        if (c == MREAD) begin
            e.data = a[8] ? 16'h0000 : shadow[a[7:0]];
            e.gcyc = cyc;
            if (p == 1) exp1.push_back(e); else exp0.push_back(e);
        end
        glog.push_back(p);
        gcount[p]++;
        lat[p] = cyc - raise_cyc[p];
        if (p == 1) got1 = 1'b1; else got0 = 1'b1;
    endtask

    task automatic on_rvalid(input int p, input logic [15:0] d);
        exp_t e;
        if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
            expect_eq(p == 1 ? "rvalid1_unexpected" : "rvalid0_unexpected", 1, 0);
        end else begin
            e = (p == 1) ? exp1.pop_front() : exp0.pop_front();
            expect_eq(p == 1 ? "rdata1" : "rdata0", {16'd0, d}, {16'd0, e.data});
            expect_eq("rvalid_latency", cyc - e.gcyc, 2);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (gnt0) on_gnt(0);
                else if (gnt1) on_gnt(1);
                else begin
                    expect_eq("idle_mem_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
                    expect_eq("idle_addr_data", {7'd0, mem_addr, write_data}, 0);
                end
            end
            if (rvalid0) on_rvalid(0, rdata0);
            if (rvalid1) on_rvalid(1, rdata1);
        end
    end

    task automatic raise(input int p, input req_t r);
        if (p == 1) begin
            req1 = 1'b1; cmd1 = r.cmd; addr1 = r.addr; wdata1 = r.wdata;
        end else begin
            req0 = 1'b1; cmd0 = r.cmd; addr0 = r.addr; wdata0 = r.wdata;
        end
        raise_cyc[p] = cyc;
    endtask

    task automatic serve(input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk); #2;
            n++;
            if (got0) begin got0 = 1'b0; req0 = 1'b0; end
            if (got1) begin got1 = 1'b0; req1 = 1'b0; end
            if (!req0 && pend0.size() > 0) raise(0, pend0.pop_front());
            if (!req1 && pend1.size() > 0) raise(1, pend1.pop_front());
            if (!req0 && !req1 && pend0.size() == 0 && pend1.size() == 0 &&
                exp0.size() == 0 && exp1.size() == 0) break;
        end
        expect_eq("serve_timeout", {31'd0, n < budget}, 1);
    endtask

    task automatic wait_got0(input int budget);
        int n = 0;
        while (!got0 && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        expect_eq("wait_gnt0_timeout", {31'd0, got0}, 1);
        got0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; got0 = 1'b0; got1 = 1'b0;
        exp0.delete(); exp1.delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        int g1_before;
        int g0_before;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_eq("rst_gnt_rvalid", {28'd0, gnt0, gnt1, rvalid0, rvalid1}, 0);
        expect_eq("rst_rdata", {rdata0, rdata1}, 0);
        expect_eq("rst_mem_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
        expect_eq("rst_addr_data", {7'd0, mem_addr, write_data}, 0);
        #2 reset = 1'b0;

        // Write then read back on port 0, checking the one-cycle grant latency.
        pend0.push_back('{MWRITE, 9'h005, 16'hABCD});
        serve(50);
        expect_eq("write_gnt_latency", lat[0], 1);
        pend0.push_back('{MREAD, 9'h005, 16'h0});
        serve(50);

        // Simultaneous reads right after reset: port 0 wins the first tie.
        pend0.push_back('{MWRITE, 9'h010, 16'h1234});
        pend1.push_back('{MWRITE, 9'h020, 16'h5678});
        serve(50);
        do_reset();
        glog.delete();
        pend0.push_back('{MREAD, 9'h010, 16'h0});
        pend1.push_back('{MREAD, 9'h020, 16'h0});
        serve(50);
        expect_eq("tie_first_gnt", glog.size() > 0 ? glog[0] : -1, 0);
        expect_eq("tie_second_gnt", glog.size() > 1 ? glog[1] : -1, 1);

        // Both held high for ten grants, mixing writes and read-backs.
        glog.delete();
        for (int i = 0; i < 5; i++) begin
            pend0.push_back('{(i % 2) ? MREAD : MWRITE, 9'h040 + 9'(i / 2), 16'($urandom)});
            pend1.push_back('{(i % 2) ? MREAD : MWRITE, 9'h050 + 9'(i / 2), 16'($urandom)});
        end
        serve(200);
        expect_eq("starve_gnt_count", glog.size(), 10);
        for (int i = 1; i < glog.size(); i++) expect_eq("starve_alternate", glog[i], glog[i-1] ^ 1);

        // Select bit set: write ignored by RAM, read forced to zero.
        pend1.push_back('{MWRITE, 9'h105, 16'h9999});
        serve(50);
        pend1.push_back('{MREAD, 9'h105, 16'h0});
        pend0.push_back('{MREAD, 9'h005, 16'h0});
        serve(50);

        // Reset lands in the RDCAP cycle: that read must never return.
        raise(0, '{MREAD, 9'h010, 16'h0});
        wait_got0(20);
        req0 = 1'b0;
        @(negedge clk); #2;
        reset = 1'b1;
        exp0.delete(); exp1.delete();
        @(negedge clk); #2;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        glog.delete();
        pend0.push_back('{MREAD, 9'h020, 16'h0});
        pend1.push_back('{MREAD, 9'h010, 16'h0});
        serve(50);
        expect_eq("post_reset_tie", glog.size() > 0 ? glog[0] : -1, 0);

        // No-op commands are granted and never produce rvalid.
        g0_before = gcount[0];
        g1_before = gcount[1];
        pend0.push_back('{2'b10, 9'h007, 16'h1111});
        pend1.push_back('{2'b11, 9'h008, 16'h2222});
        serve(50);
        repeat (4) @(negedge clk);
        expect_eq("noop_gnt0", gcount[0] - g0_before, 1);
        expect_eq("noop_gnt1", gcount[1] - g1_before, 1);

        // Port 1 raises and withdraws while the FSM is busy with a port-0 read.
        g1_before = gcount[1];
        #2;
        raise(0, '{MREAD, 9'h040, 16'h0});
        wait_got0(20);
        req0 = 1'b0;
        raise(1, '{MWRITE, 9'h010, 16'hDEAD});
        @(negedge clk); #2;
        req1 = 1'b0;
        repeat (6) @(negedge clk);
        expect_eq("withdraw_no_gnt1", gcount[1] - g1_before, 0);
        #2;
        pend1.push_back('{MREAD, 9'h010, 16'h0});
        serve(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
